mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares the single-port unified memory between instruction fetch (IF) and data access (MEM stage, driven by the decoded `readmem`/`writemem` controls). It accepts one outstanding transaction at a time, sequences the request/acknowledge handshake to memory, returns read data to the winning requester and raises per-requester stall signals for the pipeline. A watchdog aborts transactions whose memory acknowledge never arrives.

## Interface

Parameters:
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `TIMEOUT`, default 15: maximum BUSY cycles without `mem_ack` before abort; legal range 1..255.

Ports:
- `clk`: input, 1 bit. Single clock; all state updates on the rising edge.
- `rst_n`: input, 1 bit. Asynchronous, active-low reset.
- `if_req`: input, 1 bit. Fetch request level; held until `if_valid`.
- `if_addr`: input, ADDR_W bits. Fetch address; stable while `if_req`.
- `if_rdata`: output, DATA_W bits. Fetched word; valid when `if_valid`.
- `if_valid`: output, 1 bit. One-cycle completion pulse.
- `if_stall`: output, 1 bit. Equals `if_req & ~if_valid`.
- `dm_req`: input, 1 bit. Data request level (`readmem|writemem`); held until `dm_valid`.
- `dm_we`: input, 1 bit. 1 = write, 0 = read.
- `dm_addr`: input, ADDR_W bits. Data address.
- `dm_wdata`: input, DATA_W bits. Write data.
- `dm_rdata`: output, DATA_W bits. Read data; 0 after a write or an abort.
- `dm_valid`: output, 1 bit. One-cycle completion pulse.
- `dm_stall`: output, 1 bit. Equals `dm_req & ~dm_valid`.
- `mem_req`: output, 1 bit. Memory request; held until ack or abort.
- `mem_we`: output, 1 bit. Memory write enable.
- `mem_addr`: output, ADDR_W bits. Registered address.
- `mem_wdata`: output, DATA_W bits. Registered write data.
- `mem_ack`: input, 1 bit. Memory completion; counts only while `mem_req`=1.
- `mem_rdata`: input, DATA_W bits. Valid in the `mem_ack` cycle.
- `err`: output, 1 bit. One-cycle pulse on timeout abort.

## Operation

- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If `dm_req`=1, grant DM: latch `dm_addr`/`dm_wdata`/`dm_we` into the `mem_*` registers, set owner=DM and go to BUSY.
  - Otherwise, if `if_req`=1, grant IF with `mem_we`=0 and go to BUSY.
  - Otherwise remain in IDLE.
  - DM has fixed priority over IF: the older instruction wins.
- BUSY:
  - `mem_req`=1.
  - On `mem_ack`=1: capture `mem_rdata` (or 0 if `mem_we`) into the owner's rdata register and go to RESP.
  - Otherwise increment the watchdog. When the watchdog equals `TIMEOUT`, load owner rdata with 0, set `err` for the next cycle and go to RESP.
- RESP:
  - Owner's valid=1 for exactly one cycle, `mem_req`=0, then IDLE.
- The watchdog clears on entry to BUSY. Its width is 8 bits.
- The non-owner's rdata register holds its previous value. Only the owner's valid pulses.
- A request still high in the cycle after its valid is a new request and is re-arbitrated in IDLE. A held `dm_req` can therefore starve IF; the pipeline stall makes this acceptable.
- Inputs change only after completion. Changes on `*_addr`/`*_wdata` during BUSY have no effect, because the values are latched at grant.
- `mem_ack` in IDLE or RESP is ignored.

## Timing

- Reset values: state=IDLE; `mem_req`, `mem_we`, `if_valid`, `dm_valid` and `err` = 0; `mem_addr`, `mem_wdata`, `if_rdata`, `dm_rdata` and watchdog = 0.
- Stalls are combinational from the requests and valids. During reset, `if_stall`=`if_req` and `dm_stall`=`dm_req`.
- All other outputs are registered.
- Transaction timeline with the request seen in IDLE at cycle 0:
  - Cycle 1: `mem_req`=1.
  - Cycle k≥1: `mem_ack`=1.
  - Cycle k+1: valid pulses.
  - Minimum latency from request to valid is 2 cycles.
  - `mem_req` falls in cycle k+1.
- Timeout: with no ack, `mem_req` is high for cycles 1..TIMEOUT+1. Valid and `err` pulse together in cycle TIMEOUT+2.
- If `mem_ack` arrives in the same cycle the watchdog reaches `TIMEOUT`, the ack wins: data is captured and no `err`.
- Reset asserted mid-BUSY clears `mem_req` immediately (asynchronously), with no valid or `err`. After reset is released, a held request is re-arbitrated from IDLE.
- Back-to-back transactions: the next grant occurs in the cycle after RESP, so throughput is 1 transaction per 3 cycles with a zero-wait memory.

## Test plan

- **Single fetch.** Apply `if_req`=1, `if_addr`=0x0040_0000; memory acks in the first `mem_req` cycle with 0x2008_0005.
  - `mem_req` is high in cycle 1.
  - `if_valid` pulses in cycle 2 with `if_rdata`=0x2008_0005.
  - `if_stall` is 1 in cycles 0–1 and 0 in cycle 2.
- **Simultaneous requests.** Assert `if_req` and `dm_req` (read 0x1000_0010, ack returns 0xDEAD_BEEF) in the same cycle.
  - DM is served first: `dm_valid` in cycle 2, `dm_rdata`=0xDEAD_BEEF.
  - IF is granted in cycle 3: `mem_addr`=`if_addr`, `if_valid` in cycle 5.
  - `if_stall` is high throughout.
- **Write.** `dm_we`=1, `dm_addr`=0x1000_0020, `dm_wdata`=0x1234_5678, memory acks after 3 wait cycles.
  - `mem_we`=1 and `mem_wdata`=0x1234_5678 for 4 cycles.
  - `dm_valid` pulses with `dm_rdata`=0.
- **Timeout.** `TIMEOUT`=4; memory never acks.
  - `mem_req` is high for cycles 1–5.
  - `err` and `dm_valid` pulse in cycle 6 with `dm_rdata`=0.
  - State returns to IDLE.
  - A late `mem_ack` in cycle 7 is ignored.
- **Ack on the timeout boundary.** With `TIMEOUT`=4, ack in cycle 5.
  - Data is captured and `err` stays 0.
- **Reset mid-operation.** Drop `rst_n` in the second BUSY cycle.
  - `mem_req` drops in the same cycle, with no valid and no `err`.
  - After release, the held `if_req` completes normally with minimum latency 2.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data access, DM has priority, watchdog aborts hung requests.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              dm_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t      state;
  logic        owner_dm;
  logic [7:0]  wd;
  logic        wd_hit;
  assign wd_hit   = (wd == 8'(TIMEOUT));
  assign if_stall = if_req & ~if_valid;
  assign dm_stall = dm_req & ~dm_valid;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner_dm  <= 1'b0;
      wd        <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_valid  <= 1'b0;
      dm_valid  <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (dm_req | if_req) begin
          state    <= BUSY;
          mem_req  <= 1'b1;
          owner_dm <= dm_req;
          mem_we   <= dm_req & dm_we;
          mem_addr <= dm_req ? dm_addr : if_addr;
          wd       <= '0;
          if (dm_req) mem_wdata <= dm_wdata;
        end
        BUSY: if (mem_ack | wd_hit) begin
          // ack beats a simultaneous watchdog expiry
          state   <= RESP;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          err     <= ~mem_ack;
          if (owner_dm) begin
            dm_valid <= 1'b1;
            dm_rdata <= (mem_ack & ~mem_we) ? mem_rdata : '0;
          end else begin
            if_valid <= 1'b1;
            if_rdata <= mem_ack ? mem_rdata : '0;
          end
        end else begin
          wd <= wd + 8'd1;
        end
        RESP: begin
          state    <= IDLE;
          if_valid <= 1'b0;
          dm_valid <= 1'b0;
          err      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
